// File: rtl/sobel_stream_v2_pkg.sv
// rtl/sobel_stream_v2_pkg.sv - mode encodings and gradient width helper for the sobel stream
package sobel_stream_v2_pkg;

    localparam logic [1:0] MODE_BIN = 2'd0;
    localparam logic [1:0] MODE_MAG = 2'd1;
    localparam logic [1:0] MODE_INV = 2'd2;

    // Signed width that holds a 3x3 Sobel gradient of pix_w-bit taps without overflow.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_stage_reg.sv
// rtl/sobel_stage_reg.sv - one pipeline stage: payload register plus valid bit, held when en is low
module sobel_stage_reg #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/sobel_stream_v2.sv
// rtl/sobel_stream_v2.sv - 3-stage streaming Sobel edge detector with per-frame edge counter
module sobel_stream_v2
    import sobel_stream_v2_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int CNT_W = 24
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [9*PIX_W-1:0] s_axis_tdata,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tuser,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [3*PIX_W-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    input  logic [31:0]        threshold,
    input  logic [1:0]         mode,
    output logic [CNT_W-1:0]   frame_edges,
    output logic               frame_done
);

    localparam int GW   = grad_w(PIX_W);
    localparam int AW   = GW - 1;
    localparam int CW   = (AW > 32) ? AW : 32;
    localparam int S1_W = 2 + 32 + 2 + 4 * AW;
    localparam int S2_W = 2 + 32 + 2 + 2 * AW;
    localparam int S3_W = 1 + 2 + 3 * PIX_W;

    logic              ce, sof_acc;
    logic [31:0]       thr_active, thr_in;
    logic [1:0]        mode_active, mode_in;
    logic [PIX_W-1:0]  p0, p1, p2, p3, p5, p6, p7, p8;
    logic              center_unused;

    assign ce            = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = ce;
    assign sof_acc       = s_axis_tvalid & ce & s_axis_tuser;
    // A start-of-frame beat already uses the settings it brings in.
    assign thr_in        = sof_acc ? threshold : thr_active;
    assign mode_in       = sof_acc ? mode : mode_active;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            thr_active  <= '1;
            mode_active <= MODE_BIN;
        end else if (sof_acc) begin
            thr_active  <= threshold;
            mode_active <= mode;
        end
    end

    assign p0 = s_axis_tdata[0*PIX_W +: PIX_W];
    assign p1 = s_axis_tdata[1*PIX_W +: PIX_W];
    assign p2 = s_axis_tdata[2*PIX_W +: PIX_W];
    assign p3 = s_axis_tdata[3*PIX_W +: PIX_W];
    assign p5 = s_axis_tdata[5*PIX_W +: PIX_W];
    assign p6 = s_axis_tdata[6*PIX_W +: PIX_W];
    assign p7 = s_axis_tdata[7*PIX_W +: PIX_W];
    assign p8 = s_axis_tdata[8*PIX_W +: PIX_W];
    // The centre tap has zero weight in both kernels.
    assign center_unused = ^s_axis_tdata[4*PIX_W +: PIX_W];

    function automatic logic [AW-1:0] wsum(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b,
                                           input logic [PIX_W-1:0] c);
        return AW'(a) + AW'({b, 1'b0}) + AW'(c);
    endfunction

    function automatic logic [AW-1:0] sabs(input logic signed [GW-1:0] v);
        return v[GW-1] ? AW'(-v) : AW'(v);
    endfunction

    // Stage 1: the four weighted row/column sums.
    logic            s1_valid, s1_user, s1_last;
    logic [S1_W-1:0] s1_data;
    logic [1:0]      s1_mode;
    logic [31:0]     s1_thr;
    logic [AW-1:0]   s1_ya, s1_yb, s1_xa, s1_xb;

    sobel_stage_reg #(.W(S1_W)) u_stage1 (
        .aclk      (aclk),
        .areset    (areset),
        .en        (ce),
        .in_valid  (s_axis_tvalid),
        .in_data   ({mode_in, thr_in, s_axis_tuser, s_axis_tlast,
                     wsum(p0, p1, p2), wsum(p6, p7, p8), wsum(p0, p3, p6), wsum(p2, p5, p8)}),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );
    assign {s1_mode, s1_thr, s1_user, s1_last, s1_ya, s1_yb, s1_xa, s1_xb} = s1_data;

    // Stage 2: signed gradients reduced to magnitudes.
    logic signed [GW-1:0] gx, gy;
    logic                 s2_valid, s2_user, s2_last;
    logic [S2_W-1:0]      s2_data;
    logic [1:0]           s2_mode;
    logic [31:0]          s2_thr;
    logic [AW-1:0]        s2_ax, s2_ay;

    assign gy = $signed({1'b0, s1_ya}) - $signed({1'b0, s1_yb});
    assign gx = $signed({1'b0, s1_xa}) - $signed({1'b0, s1_xb});

    sobel_stage_reg #(.W(S2_W)) u_stage2 (
        .aclk      (aclk),
        .areset    (areset),
        .en        (ce),
        .in_valid  (s1_valid),
        .in_data   ({s1_mode, s1_thr, s1_user, s1_last, sabs(gx), sabs(gy)}),
        .out_valid (s2_valid),
        .out_data  (s2_data)
    );
    assign {s2_mode, s2_thr, s2_user, s2_last, s2_ax, s2_ay} = s2_data;

    // Stage 3: threshold compare and output formatting.
    logic [GW-1:0]    mag_sum;
    logic             edge_flag;
    logic [PIX_W-1:0] pix;

    always_comb begin
        mag_sum   = GW'(s2_ax) + GW'(s2_ay);
        edge_flag = (CW'(s2_ax) > CW'(s2_thr)) || (CW'(s2_ay) > CW'(s2_thr));
        pix       = '0;
        case (s2_mode)
            MODE_MAG: pix = (|mag_sum[GW-1:PIX_W]) ? '1 : mag_sum[PIX_W-1:0];
            MODE_INV: pix = edge_flag ? '0 : '1;
            default:  pix = edge_flag ? '1 : '0;
        endcase
    end

    logic            m_edge;
    logic [S3_W-1:0] s3_data;

    sobel_stage_reg #(.W(S3_W)) u_stage3 (
        .aclk      (aclk),
        .areset    (areset),
        .en        (ce),
        .in_valid  (s2_valid),
        .in_data   ({edge_flag, s2_user, s2_last, {3{pix}}}),
        .out_valid (m_axis_tvalid),
        .out_data  (s3_data)
    );
    assign {m_edge, m_axis_tuser, m_axis_tlast, m_axis_tdata} = s3_data;

    logic [CNT_W-1:0] edge_cnt;
    logic             m_hs;

    assign m_hs = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            edge_cnt    <= '0;
            frame_edges <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (m_hs) begin
                if (m_axis_tuser) begin
                    frame_edges <= edge_cnt;
                    frame_done  <= 1'b1;
                    edge_cnt    <= CNT_W'(m_edge);
                end else if (m_edge && (edge_cnt != '1)) begin
                    edge_cnt <= edge_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_v2.sv
// tb/tb_sobel_stream_v2.sv - directed vector bench for sobel_stream_v2
module tb_sobel_stream_v2;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [71:0] s_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [23:0] m_axis_tdata;
    logic [31:0] threshold;
    logic [1:0]  mode;
    logic [23:0] frame_edges;
    logic        frame_done;

    sobel_stream_v2 #(.PIX_W(8), .CNT_W(24)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .threshold     (threshold),
        .mode          (mode),
        .frame_edges   (frame_edges),
        .frame_done    (frame_done)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [71:0] win;
        logic [31:0] thr;
        logic [1:0]  mode;
        logic [23:0] exp;
        logic        edg;
    } vec_t;

    vec_t        vecs [16];
    logic [71:0] b_win  [24];
    logic [31:0] b_thr  [24];
    logic [1:0]  b_mode [24];
    logic [23:0] b_exp  [24];
    logic        b_last [24];
    logic        b_user [24];
    int          checks = 0;
    int          failures = 0;
    int          pulse_cnt;
    logic [23:0] pulse_edges [4];

    function automatic logic [71:0] win9(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                         input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
                                         input logic [7:0] a6, input logic [7:0] a7, input logic [7:0] a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic one_beat(input int i);
        int lat;
        @(negedge aclk);
        s_axis_tvalid = 1'b1; s_axis_tdata = vecs[i].win; s_axis_tuser = 1'b1; s_axis_tlast = 1'b1;
        threshold = vecs[i].thr; mode = vecs[i].mode;
        lat = 0;
        do begin
            @(negedge aclk);
            s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
            lat++;
            #1;
        end while (!m_axis_tvalid && lat < 10);
        chk($sformatf("vec%0d_latency", i), lat, 3);
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].exp);
        chk($sformatf("vec%0d_tuser", i), m_axis_tuser, 1);
        @(negedge aclk); #1;
        chk($sformatf("vec%0d_frame_done", i), frame_done, 1);
        chk($sformatf("vec%0d_frame_edges", i), frame_edges, (i == 0) ? 24'd0 : 24'(vecs[i-1].edg));
        @(negedge aclk); #1;
        chk($sformatf("vec%0d_done_pulse", i), frame_done, 0);
    endtask

    task automatic run_stream(input int n, input int st0, input int stlen);
        int sent, got, cyc, idle;
        sent = 0; got = 0; cyc = 0; idle = 0; pulse_cnt = 0;
        while (idle < 3 && cyc < 400) begin
            @(negedge aclk);
            m_axis_tready = !(cyc >= st0 && cyc < st0 + stlen);
            if (sent < n) begin
                s_axis_tvalid = 1'b1; s_axis_tdata = b_win[sent];
                s_axis_tlast = b_last[sent]; s_axis_tuser = b_user[sent];
                threshold = b_thr[sent]; mode = b_mode[sent];
            end else begin
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
            end
            #1;
            if (frame_done) begin
                if (pulse_cnt < 4) pulse_edges[pulse_cnt] = frame_edges;
                pulse_cnt++;
            end
            if (m_axis_tvalid && !m_axis_tready)
                chk("stall_s_tready", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (got < n) begin
                    chk($sformatf("beat%0d_tdata", got), m_axis_tdata, b_exp[got]);
                    chk($sformatf("beat%0d_tlast", got), m_axis_tlast, b_last[got]);
                    chk($sformatf("beat%0d_tuser", got), m_axis_tuser, b_user[got]);
                end else begin
                    chk("extra_beat", got + 1, n);
                end
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            if (got >= n) idle++;
            cyc++;
        end
        chk("stream_count", got, n);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; m_axis_tready = 1'b1;
    endtask

    initial begin
        int stale;
        logic [7:0] e;
        logic is_edge;

        vecs[0]  = '{win9(100,100,100,100,100,100,100,100,100), 32'd10, 2'd0, 24'h000000, 1'b0};
        vecs[1]  = '{win9(255,255,255,0,0,0,0,0,0), 32'd500, 2'd0, 24'hFFFFFF, 1'b1};
        vecs[2]  = '{win9(255,255,255,0,0,0,0,0,0), 32'd500, 2'd2, 24'h000000, 1'b1};
        vecs[3]  = '{win9(10,10,10,0,0,0,0,0,0), 32'd100, 2'd1, 24'h282828, 1'b0};
        vecs[4]  = '{win9(255,255,255,0,0,0,0,0,0), 32'd500, 2'd1, 24'hFFFFFF, 1'b1};
        vecs[5]  = '{win9(255,255,255,0,0,0,0,0,0), 32'd500, 2'd3, 24'hFFFFFF, 1'b1};
        vecs[6]  = '{win9(10,10,10,0,0,0,0,0,0), 32'd40, 2'd0, 24'h000000, 1'b0};
        vecs[7]  = '{win9(10,10,10,0,0,0,0,0,0), 32'd39, 2'd0, 24'hFFFFFF, 1'b1};
        vecs[8]  = '{win9(50,0,0,50,0,0,50,0,0), 32'd199, 2'd0, 24'hFFFFFF, 1'b1};
        vecs[9]  = '{win9(50,0,0,50,0,0,50,0,0), 32'd200, 2'd1, 24'hC8C8C8, 1'b0};
        vecs[10] = '{win9(0,0,0,0,0,0,20,20,20), 32'd79, 2'd2, 24'h000000, 1'b1};
        vecs[11] = '{win9(0,0,0,0,0,0,20,20,20), 32'd0, 2'd1, 24'h505050, 1'b1};
        vecs[12] = '{win9(30,0,0,0,0,0,0,0,0), 32'd1000, 2'd1, 24'h3C3C3C, 1'b0};
        vecs[13] = '{win9(255,0,0,0,0,0,0,0,0), 32'hFFFFFFFF, 2'd1, 24'hFFFFFF, 1'b0};
        vecs[14] = '{win9(255,255,255,0,0,0,0,0,0), 32'hFFFFFFFF, 2'd0, 24'h000000, 1'b0};
        vecs[15] = '{win9(0,0,50,0,0,50,0,0,50), 32'd150, 2'd0, 24'hFFFFFF, 1'b1};

        areset = 1'b1; m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; threshold = '0; mode = '0;
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_s_tready", s_axis_tready, 1);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_frame_edges", frame_edges, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge aclk);
        areset = 1'b0;

        for (int i = 0; i < 16; i++) one_beat(i);

        for (int i = 0; i < 20; i++) begin
            e = 8'(4 * (i + 1));
            b_win[i] = win9(8'(i + 1), 8'(i + 1), 8'(i + 1), 0, 0, 0, 0, 0, 0);
            b_last[i] = (i % 5 == 4); b_user[i] = (i == 0);
            b_thr[i] = 32'hFFFFFFFF; b_mode[i] = 2'd1; b_exp[i] = {e, e, e};
        end
        run_stream(20, 8, 5);
        chk("stall_done_pulses", pulse_cnt, 1);
        chk("stall_prev_edges", pulse_edges[0], 1);

        for (int i = 0; i < 17; i++) begin
            is_edge = (i == 1 || i == 3 || i == 5 || i == 9 || i == 11 || i == 13);
            b_win[i] = (is_edge || i == 16) ? win9(255, 255, 255, 0, 0, 0, 0, 0, 0) : '0;
            b_user[i] = (i == 0 || i == 16); b_last[i] = (i == 15);
            b_thr[i] = (i == 16) ? 32'd2000 : (i >= 8 ? 32'hFFFFFFFF : 32'd100);
            b_mode[i] = 2'd0; b_exp[i] = is_edge ? 24'hFFFFFF : 24'h000000;
        end
        run_stream(17, 1000, 0);
        chk("frame_done_pulses", pulse_cnt, 2);
        chk("frame_prev_edges", pulse_edges[0], 0);
        chk("frame_edges_6", pulse_edges[1], 6);

        @(negedge aclk);
        s_axis_tvalid = 1'b1; s_axis_tdata = win9(255, 255, 255, 0, 0, 0, 0, 0, 0);
        s_axis_tuser = 1'b1; threshold = 32'd0; mode = 2'd0;
        @(negedge aclk);
        s_axis_tuser = 1'b0;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        @(negedge aclk); #1;
        chk("rst_pre_valid", m_axis_tvalid, 1);
        areset = 1'b1; #1;
        chk("rst_async_valid", m_axis_tvalid, 0);
        chk("rst_async_tdata", m_axis_tdata, 0);
        chk("rst_async_edges", frame_edges, 0);
        chk("rst_held_s_tready", s_axis_tready, 1);
        @(negedge aclk);
        areset = 1'b0;
        stale = 0;
        repeat (6) begin
            @(negedge aclk); #1;
            if (m_axis_tvalid) stale++;
        end
        chk("rst_no_stale", stale, 0);

        b_win[0] = win9(255, 255, 255, 0, 0, 0, 0, 0, 0); b_user[0] = 1'b0; b_last[0] = 1'b0;
        b_thr[0] = 32'd0; b_mode[0] = 2'd1; b_exp[0] = 24'h000000;
        run_stream(1, 1000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
